// File: rtl/dcache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the
// direct-mapped write-back data cache.
package dcache_pkg;

    localparam int unsigned BLOCK_W        = 256;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned OFFSET_W       = 5;
    localparam int unsigned WORDS_PER_LINE = BLOCK_W / WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REFILL
    } state_e;

    // Results are full-width; callers keep the low INDEX_W / TAG_W bits.
    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int unsigned num_lines);
        return (addr >> OFFSET_W) & (num_lines - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int unsigned num_lines);
        return addr >> (OFFSET_W + $clog2(num_lines));
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: valid/dirty/tag/data per line, one
// combinational read port, a word-write port and a whole-line fill port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 16,
    parameter int unsigned INDEX_W   = $clog2(NUM_LINES),
    parameter int unsigned TAG_W     = 32 - OFFSET_W - INDEX_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [INDEX_W-1:0] idx_i,
    output logic               valid_o,
    output logic               dirty_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [BLOCK_W-1:0] line_o,
    input  logic               word_we_i,
    input  logic [2:0]         word_sel_i,
    input  logic [WORD_W-1:0]  word_data_i,
    input  logic               line_we_i,
    input  logic [TAG_W-1:0]   line_tag_i,
    input  logic [BLOCK_W-1:0] line_data_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_q [NUM_LINES];
    logic [7:0]           word_lsb;

    assign word_lsb = {word_sel_i, 5'b0};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data need no reset: a line is only observed once its valid bit is set.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= line_tag_i;
            data_q[idx_i] <= line_data_i;
        end else if (word_we_i) begin
            data_q[idx_i][word_lsb +: WORD_W] <= word_data_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: hit path,
// miss FSM (IDLE/WB/REFILL) and block interface to data memory.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [31:0]         data_address_2DM,
    input  logic [31:0]         data_write_2DM,
    output logic [31:0]         data_read_fDM,
    output logic                FREEZE,
    output logic                dBlkRead,
    output logic                dBlkWrite,
    output logic [31:0]         dBlk_address,
    output logic [BLOCK_W-1:0]  block_write_2DM,
    input  logic [BLOCK_W-1:0]  block_read_fDM,
    input  logic                dBlkDone
);

    localparam int unsigned INDEX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W   = 32 - OFFSET_W - INDEX_W;

    state_e               state_q, state_d;
    logic [INDEX_W-1:0]   miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
    logic [WORD_W-1:0]    rdata_q, rdata_d;

    logic [31:0]          req_idx_full, req_tag_full;
    logic [INDEX_W-1:0]   req_idx, arr_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [2:0]           req_word;
    logic                 req, hit, load_hit;
    logic                 unused_bits;

    logic                 arr_valid, arr_dirty;
    logic [TAG_W-1:0]     arr_tag;
    logic [BLOCK_W-1:0]   arr_line;
    logic [WORD_W-1:0]    arr_word;
    logic                 word_we, line_we;
    logic                 freeze_raw;

    assign req_idx_full = addr_index(data_address_2DM, NUM_LINES);
    assign req_tag_full = addr_tag(data_address_2DM, NUM_LINES);
    assign req_idx      = req_idx_full[INDEX_W-1:0];
    assign req_tag      = req_tag_full[TAG_W-1:0];
    assign req_word     = data_address_2DM[4:2];
    assign unused_bits  = ^{data_address_2DM[1:0], req_idx_full[31:INDEX_W],
                            req_tag_full[31:TAG_W]};

    assign req = MemRead | MemWrite;

    // During a transfer the array is addressed by the latched miss line.
    assign arr_idx  = (state_q == IDLE) ? req_idx : miss_idx_q;
    assign arr_word = arr_line[{req_word, 5'b0} +: WORD_W];
    assign hit      = (state_q == IDLE) && arr_valid && (arr_tag == req_tag);
    assign load_hit = hit && MemRead && !MemWrite;

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk_i       (CLK),
        .rst_ni      (RESET),
        .idx_i       (arr_idx),
        .valid_o     (arr_valid),
        .dirty_o     (arr_dirty),
        .tag_o       (arr_tag),
        .line_o      (arr_line),
        .word_we_i   (word_we),
        .word_sel_i  (req_word),
        .word_data_i (data_write_2DM),
        .line_we_i   (line_we),
        .line_tag_i  (miss_tag_q),
        .line_data_i (block_read_fDM)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        miss_idx_d      = miss_idx_q;
        miss_tag_d      = miss_tag_q;
        rdata_d         = rdata_q;
        freeze_raw      = 1'b0;
        dBlkRead        = 1'b0;
        dBlkWrite       = 1'b0;
        dBlk_address    = '0;
        block_write_2DM = '0;
        word_we         = 1'b0;
        line_we         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        word_we = MemWrite;
                        if (load_hit) begin
                            rdata_d = arr_word;
                        end
                    end else begin
                        freeze_raw = 1'b1;
                        miss_idx_d = req_idx;
                        miss_tag_d = req_tag;
                        state_d    = (arr_valid && arr_dirty) ? WB : REFILL;
                    end
                end
            end
            WB: begin
                freeze_raw      = 1'b1;
                dBlkWrite       = 1'b1;
                dBlk_address    = {arr_tag, miss_idx_q, 5'b0};
                block_write_2DM = arr_line;
                if (dBlkDone) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                freeze_raw   = 1'b1;
                dBlkRead     = 1'b1;
                dBlk_address = {miss_tag_q, miss_idx_q, 5'b0};
                if (dBlkDone) begin
                    line_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A held request would otherwise raise the miss stall while reset is asserted.
    assign FREEZE        = freeze_raw & RESET;
    assign data_read_fDM = load_hit ? arr_word : rdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold miss, hits, dirty and clean eviction,
// write-allocate, reset during refill and simultaneous read/write.
module tb_dcache_ctrl;

    logic         CLK;
    logic         RESET;
    logic         MemRead;
    logic         MemWrite;
    logic [31:0]  data_address_2DM;
    logic [31:0]  data_write_2DM;
    logic [31:0]  data_read_fDM;
    logic         FREEZE;
    logic         dBlkRead;
    logic         dBlkWrite;
    logic [31:0]  dBlk_address;
    logic [255:0] block_write_2DM;
    logic [255:0] block_read_fDM;
    logic         dBlkDone;

    int unsigned total = 0;
    int unsigned bad   = 0;

    dcache_ctrl #(.NUM_LINES(16)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .data_address_2DM (data_address_2DM),
        .data_write_2DM   (data_write_2DM),
        .data_read_fDM    (data_read_fDM),
        .FREEZE           (FREEZE),
        .dBlkRead         (dBlkRead),
        .dBlkWrite        (dBlkWrite),
        .dBlk_address     (dBlk_address),
        .block_write_2DM  (block_write_2DM),
        .block_read_fDM   (block_read_fDM),
        .dBlkDone         (dBlkDone)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
        MemRead          = rd;
        MemWrite         = wr;
        data_address_2DM = addr;
        data_write_2DM   = wdata;
    endtask

    // Word i of a memory block is base+i.
    function automatic logic [255:0] mk_blk(input logic [31:0] base);
        logic [255:0] b;
        for (int i = 0; i < 8; i++) begin
            b[32*i +: 32] = base + 32'(i);
        end
        return b;
    endfunction

    // Called on the first cycle a transfer is visible; completes it after lat cycles.
    task automatic mem_finish(input int lat, input logic [255:0] blk);
        for (int i = 1; i < lat; i++) begin
            tick(); #1;
            chk("frz_busy", FREEZE, 1'b1);
        end
        tick();
        block_read_fDM = blk;
        dBlkDone       = 1'b1;
        #1;
        chk("frz_done_cycle", FREEZE, 1'b1);
        tick();
        dBlkDone       = 1'b0;
        block_read_fDM = '0;
        #1;
    endtask

    initial begin
        RESET          = 1'b0;
        req(1'b0, 1'b0, 32'h0, 32'h0);
        block_read_fDM = '0;
        dBlkDone       = 1'b0;
        tick(); tick(); #1;
        chk("rst_freeze", FREEZE, 1'b0);
        chk("rst_blkrd", dBlkRead, 1'b0);
        chk("rst_blkwr", dBlkWrite, 1'b0);
        chk("rst_addr", dBlk_address, 32'h0);
        chk("rst_wblk", block_write_2DM, 256'h0);
        chk("rst_rdata", data_read_fDM, 32'h0);
        RESET = 1'b1;

        // cold load miss
        tick(); req(1'b1, 1'b0, 32'h40, 32'h0); #1;
        chk("cold_freeze", FREEZE, 1'b1);
        chk("cold_blkrd_idle", dBlkRead, 1'b0);
        tick(); #1;
        chk("cold_blkrd", dBlkRead, 1'b1);
        chk("cold_blkwr", dBlkWrite, 1'b0);
        chk("cold_addr", dBlk_address, 32'h40);
        mem_finish(4, mk_blk(32'hDEADBEEF));
        chk("cold_freeze_fall", FREEZE, 1'b0);
        chk("cold_rdata", data_read_fDM, 32'hDEADBEEF);
        chk("cold_blkrd_off", dBlkRead, 1'b0);
        tick(); req(1'b0, 1'b0, 32'h0, 32'h0); #1;
        chk("idle_hold_rdata", data_read_fDM, 32'hDEADBEEF);
        chk("idle_freeze", FREEZE, 1'b0);
        tick(); req(1'b1, 1'b0, 32'h40, 32'h0); #1;
        chk("hit40_freeze", FREEZE, 1'b0);
        chk("hit40_rdata", data_read_fDM, 32'hDEADBEEF);
        tick(); req(1'b1, 1'b0, 32'h48, 32'h0); #1;
        chk("hit48_rdata", data_read_fDM, 32'hDEADBEF1);

        // store hit, then dirty eviction
        tick(); req(1'b0, 1'b1, 32'h44, 32'h12345678); #1;
        chk("sthit_freeze", FREEZE, 1'b0);
        tick(); req(1'b1, 1'b0, 32'h44, 32'h0); #1;
        chk("sthit_readback", data_read_fDM, 32'h12345678);
        tick(); req(1'b1, 1'b0, 32'h240, 32'h0); #1;
        chk("dirty_freeze", FREEZE, 1'b1);
        tick(); #1;
        chk("wb_blkwr", dBlkWrite, 1'b1);
        chk("wb_blkrd", dBlkRead, 1'b0);
        chk("wb_addr", dBlk_address, 32'h40);
        chk("wb_word1", block_write_2DM[63:32], 32'h12345678);
        chk("wb_word0", block_write_2DM[31:0], 32'hDEADBEEF);
        mem_finish(2, '0);
        chk("wb2rf_blkwr", dBlkWrite, 1'b0);
        chk("wb2rf_blkrd", dBlkRead, 1'b1);
        chk("wb2rf_addr", dBlk_address, 32'h240);
        mem_finish(3, mk_blk(32'h24000000));
        chk("dirty_freeze_fall", FREEZE, 1'b0);
        chk("dirty_rdata", data_read_fDM, 32'h24000000);

        // clean eviction
        tick(); req(1'b1, 1'b0, 32'h80, 32'h0); #1;
        chk("c80_freeze", FREEZE, 1'b1);
        tick(); #1;
        chk("c80_blkrd", dBlkRead, 1'b1);
        chk("c80_addr", dBlk_address, 32'h80);
        mem_finish(2, mk_blk(32'h80));
        chk("c80_rdata", data_read_fDM, 32'h80);
        tick(); req(1'b1, 1'b0, 32'h280, 32'h0); #1;
        chk("c280_freeze", FREEZE, 1'b1);
        tick(); #1;
        chk("c280_no_wb", dBlkWrite, 1'b0);
        chk("c280_blkrd", dBlkRead, 1'b1);
        chk("c280_addr", dBlk_address, 32'h280);
        mem_finish(2, mk_blk(32'h280));
        chk("c280_rdata", data_read_fDM, 32'h280);

        // store miss, write-allocate
        tick(); req(1'b0, 1'b1, 32'h1C, 32'hA5A5A5A5); #1;
        chk("stmiss_freeze", FREEZE, 1'b1);
        tick(); #1;
        chk("stmiss_blkrd", dBlkRead, 1'b1);
        chk("stmiss_no_wb", dBlkWrite, 1'b0);
        chk("stmiss_addr", dBlk_address, 32'h0);
        mem_finish(2, mk_blk(32'h100));
        chk("stmiss_freeze_fall", FREEZE, 1'b0);
        tick(); req(1'b1, 1'b0, 32'h1C, 32'h0); #1;
        chk("stmiss_word7", data_read_fDM, 32'hA5A5A5A5);
        tick(); req(1'b1, 1'b0, 32'h18, 32'h0); #1;
        chk("stmiss_word6", data_read_fDM, 32'h106);
        tick(); req(1'b1, 1'b0, 32'h200, 32'h0); #1;
        chk("ev0_freeze", FREEZE, 1'b1);
        tick(); #1;
        chk("ev0_blkwr", dBlkWrite, 1'b1);
        chk("ev0_addr", dBlk_address, 32'h0);
        chk("ev0_word7", block_write_2DM[255:224], 32'hA5A5A5A5);
        chk("ev0_word6", block_write_2DM[223:192], 32'h106);
        mem_finish(2, '0);
        chk("ev0_rf_addr", dBlk_address, 32'h200);
        mem_finish(2, mk_blk(32'h200));
        chk("ev0_rdata", data_read_fDM, 32'h200);

        // reset during refill
        tick(); req(1'b1, 1'b0, 32'h300, 32'h0);
        tick(); #1;
        chk("rr_blkrd", dBlkRead, 1'b1);
        tick();
        RESET = 1'b0;
        #1;
        chk("rr_blkrd_off", dBlkRead, 1'b0);
        chk("rr_freeze_off", FREEZE, 1'b0);
        chk("rr_addr_zero", dBlk_address, 32'h0);
        chk("rr_rdata_zero", data_read_fDM, 32'h0);
        tick();
        RESET = 1'b1;
        #1;
        chk("rr_remiss", FREEZE, 1'b1);
        chk("rr_idle", dBlkRead, 1'b0);
        tick(); #1;
        chk("rr_refill_again", dBlkRead, 1'b1);
        chk("rr_refill_addr", dBlk_address, 32'h300);
        mem_finish(2, mk_blk(32'h300));
        chk("rr_rdata", data_read_fDM, 32'h300);
        tick(); req(1'b1, 1'b0, 32'h280, 32'h0); #1;
        chk("rr_280_invalid", FREEZE, 1'b1);
        tick(); #1;
        chk("rr_280_no_wb", dBlkWrite, 1'b0);
        chk("rr_280_blkrd", dBlkRead, 1'b1);
        mem_finish(2, mk_blk(32'h280));

        // stray dBlkDone in IDLE
        tick(); req(1'b0, 1'b0, 32'h0, 32'h0);
        dBlkDone = 1'b1;
        #1;
        chk("stray_freeze", FREEZE, 1'b0);
        tick();
        dBlkDone = 1'b0;
        #1;
        chk("stray_blkrd", dBlkRead, 1'b0);
        chk("stray_blkwr", dBlkWrite, 1'b0);

        // simultaneous read and write acts as a store
        tick(); req(1'b1, 1'b1, 32'h300, 32'hCAFEF00D); #1;
        chk("rw_freeze", FREEZE, 1'b0);
        tick(); req(1'b1, 1'b0, 32'h300, 32'h0); #1;
        chk("rw_readback", data_read_fDM, 32'hCAFEF00D);
        tick(); req(1'b1, 1'b0, 32'h100, 32'h0); #1;
        chk("rw_evict_freeze", FREEZE, 1'b1);
        tick(); #1;
        chk("rw_dirty_wb", dBlkWrite, 1'b1);
        chk("rw_wb_addr", dBlk_address, 32'h300);
        chk("rw_wb_word0", block_write_2DM[31:0], 32'hCAFEF00D);
        mem_finish(2, '0);
        chk("rw_rf_addr", dBlk_address, 32'h100);
        mem_finish(2, mk_blk(32'h100));
        chk("rw_rdata", data_read_fDM, 32'h100);

        tick(); req(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
